// File: rtl/vend_pkg.sv
// Shared constants for the vending sequencer: calculator opcodes, register map,
// coin encodings/values and FSM state codes.
package vend_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_LDI  = 3'b011;

    localparam logic [3:0] R_NULL  = 4'd0;
    localparam logic [3:0] R_PAID  = 4'd4;
    localparam logic [3:0] R_PRICE = 4'd5;

    localparam logic [1:0] COIN_NICKEL  = 2'b00;
    localparam logic [1:0] COIN_DIME    = 2'b01;
    localparam logic [1:0] COIN_QUARTER = 2'b10;
    localparam logic [1:0] COIN_DOLLAR  = 2'b11;

    localparam logic [3:0] VAL_NICKEL  = 4'd1;
    localparam logic [3:0] VAL_DIME    = 4'd2;
    localparam logic [3:0] VAL_QUARTER = 4'd5;

    typedef logic [2:0] state_t;
    localparam state_t S_CLR     = 3'd0;
    localparam state_t S_IDLE    = 3'd1;
    localparam state_t S_ADD     = 3'd2;
    localparam state_t S_LDPRICE = 3'd3;
    localparam state_t S_DEDUCT  = 3'd4;
    localparam state_t S_VEND    = 3'd5;
    localparam state_t S_CHANGE  = 3'd6;

    function automatic logic credit_overflow(input logic [9:0]  paid,
                                             input logic [3:0]  value,
                                             input logic [10:0] limit);
        return ({1'b0, paid} + {7'd0, value}) > limit;
    endfunction

endpackage

// File: rtl/vend_coin_decode.sv
// Maps the 2-bit coin code to its value in 5-cent units; the dollar code is not accepted.
module vend_coin_decode
    import vend_pkg::*;
(
    input  logic [1:0] coin_type,
    output logic [3:0] value,
    output logic       valid
);

    always_comb begin
        value = '0;
        valid = 1'b1;
        case (coin_type)
            COIN_NICKEL:  value = VAL_NICKEL;
            COIN_DIME:    value = VAL_DIME;
            COIN_QUARTER: value = VAL_QUARTER;
            default:      valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/vend_sequencer.sv
// Turns coin/selection/cancel events into calculator micro-ops and decides
// vend, deny, reject and change from the credit register read back as paid.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE0     = 13,
    parameter int PRICE1     = 10,
    parameter int PRICE2     = 15,
    parameter int PRICE3     = 5,
    parameter int MAX_CREDIT = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    output logic       coin_ready,
    output logic       coin_reject,
    input  logic       sel_valid,
    input  logic [1:0] sel_item,
    output logic       sel_ready,
    input  logic       cancel,
    output logic       deny,
    output logic       vend,
    output logic [1:0] vend_item,
    output logic       change_valid,
    output logic [9:0] change_units,
    input  logic       change_ack,
    input  logic [9:0] paid,
    output logic [2:0] op,
    output logic [3:0] rw,
    output logic [3:0] ra,
    output logic [3:0] rb,
    output logic [3:0] imm4
);

    state_t     st, st_n;
    logic       pend, pend_n;
    logic [1:0] pitem, pitem_n, item, item_n;
    logic [3:0] coin_val;
    logic       coin_ok;
    logic       coin_reject_n, deny_n, change_valid_n;
    logic [9:0] change_units_n;
    logic [2:0] op_n;
    logic [3:0] rw_n, ra_n, rb_n, imm4_n;

    vend_coin_decode u_dec (
        .coin_type (coin_type),
        .value     (coin_val),
        .valid     (coin_ok)
    );

    function automatic logic [3:0] price_of(input logic [1:0] i);
        case (i)
            2'd0:    return 4'(PRICE0);
            2'd1:    return 4'(PRICE1);
            2'd2:    return 4'(PRICE2);
            default: return 4'(PRICE3);
        endcase
    endfunction

    always_comb begin
        st_n           = st;
        pend_n         = pend;
        pitem_n        = pitem;
        item_n         = item;
        coin_reject_n  = 1'b0;
        deny_n         = 1'b0;
        change_valid_n = change_valid;
        change_units_n = change_units;
        case (st)
            // First CLR cycle after reset carries no write; hold until LDI r4 has been issued.
            S_CLR: if (rw == R_PAID) st_n = S_IDLE;
            S_IDLE: begin
                // A selection that handshakes alongside a coin is parked and served after it.
                if (sel_valid && sel_ready) begin
                    pend_n  = 1'b1;
                    pitem_n = sel_item;
                end
                if (coin_valid && coin_ready) begin
                    if (!coin_ok || credit_overflow(paid, coin_val, 11'(MAX_CREDIT)))
                        coin_reject_n = 1'b1;
                    else
                        st_n = S_ADD;
                end else if (pend_n) begin
                    pend_n = 1'b0;
                    item_n = pitem_n;
                    if (paid < {6'd0, price_of(pitem_n)}) deny_n = 1'b1;
                    else                                  st_n   = S_LDPRICE;
                end else if (cancel && paid != '0) begin
                    st_n           = S_CHANGE;
                    change_valid_n = 1'b1;
                    change_units_n = paid;
                end
            end
            S_ADD:     st_n = S_IDLE;
            S_LDPRICE: st_n = S_DEDUCT;
            S_DEDUCT:  st_n = S_VEND;
            S_VEND: begin
                if (paid == '0) begin
                    st_n = S_CLR;
                end else begin
                    st_n           = S_CHANGE;
                    change_valid_n = 1'b1;
                    change_units_n = paid;
                end
            end
            S_CHANGE: begin
                if (change_ack) begin
                    st_n           = S_CLR;
                    change_valid_n = 1'b0;
                end
            end
            default: st_n = S_CLR;
        endcase
    end

    always_comb begin
        op_n   = OP_LDI;
        rw_n   = R_NULL;
        ra_n   = R_NULL;
        rb_n   = R_NULL;
        imm4_n = '0;
        case (st_n)
            S_CLR: rw_n = R_PAID;
            S_ADD: begin
                op_n   = OP_ADDI;
                rw_n   = R_PAID;
                ra_n   = R_PAID;
                imm4_n = coin_val;
            end
            S_LDPRICE: begin
                rw_n   = R_PRICE;
                imm4_n = price_of(item_n);
            end
            S_DEDUCT: begin
                op_n = OP_SUB;
                rw_n = R_PAID;
                ra_n = R_PAID;
                rb_n = R_PRICE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st           <= S_CLR;
            pend         <= 1'b0;
            pitem        <= '0;
            item         <= '0;
            coin_ready   <= 1'b0;
            sel_ready    <= 1'b0;
            coin_reject  <= 1'b0;
            deny         <= 1'b0;
            vend         <= 1'b0;
            vend_item    <= '0;
            change_valid <= 1'b0;
            change_units <= '0;
            op           <= OP_LDI;
            rw           <= R_NULL;
            ra           <= R_NULL;
            rb           <= R_NULL;
            imm4         <= '0;
        end else begin
            st           <= st_n;
            pend         <= pend_n;
            pitem        <= pitem_n;
            item         <= item_n;
            coin_ready   <= (st_n == S_IDLE);
            sel_ready    <= (st_n == S_IDLE) && !pend_n;
            coin_reject  <= coin_reject_n;
            deny         <= deny_n;
            vend         <= (st_n == S_VEND);
            if (st_n == S_VEND) vend_item <= item_n;
            change_valid <= change_valid_n;
            change_units <= change_units_n;
            op           <= op_n;
            rw           <= rw_n;
            ra           <= ra_n;
            rb           <= rb_n;
            imm4         <= imm4_n;
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: a calculator register-file model closes the paid loop,
// a credit-level reference model predicts events, and a monitor scores DUT outputs.
module tb_vend_sequencer;

    localparam int MAXC = 200;
    localparam int EV_REJ = 1, EV_DENY = 2, EV_VEND = 3, EV_CHG = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0, sel_valid = 1'b0, cancel = 1'b0, change_ack = 1'b0;
    logic [1:0] coin_type = '0, sel_item = '0;
    logic       coin_ready, coin_reject, sel_ready, deny, vend, change_valid;
    logic [1:0] vend_item;
    logic [9:0] change_units, paid;
    logic [2:0] op;
    logic [3:0] rw, ra, rb, imm4;

    always #5 clk = ~clk;

    vend_sequencer #(.PRICE0(13), .PRICE1(10), .PRICE2(15), .PRICE3(5), .MAX_CREDIT(MAXC)) dut (
        .clk(clk), .rst_n(rst_n),
        .coin_valid(coin_valid), .coin_type(coin_type), .coin_ready(coin_ready), .coin_reject(coin_reject),
        .sel_valid(sel_valid), .sel_item(sel_item), .sel_ready(sel_ready),
        .cancel(cancel), .deny(deny), .vend(vend), .vend_item(vend_item),
        .change_valid(change_valid), .change_units(change_units), .change_ack(change_ack),
        .paid(paid), .op(op), .rw(rw), .ra(ra), .rb(rb), .imm4(imm4)
    );

    // Calculator: register file without reset, written on the edge ending each micro-op.
    logic [9:0] rf [16] = '{default: 10'd777};
    logic [9:0] res;
    always @(posedge clk) begin
        case (op)
            3'b000:  res = rf[ra] + rf[rb];
            3'b001:  res = rf[ra] - rf[rb];
            3'b010:  res = rf[ra] + {6'd0, imm4};
            default: res = {6'd0, imm4};
        endcase
        if (rw != 4'd0) rf[rw] <= res;
    end
    assign paid = rf[4];

    int ncmp = 0, nfail = 0;
    int credit = 0;
    int left_after = 0;
    int price_tb [4] = '{13, 10, 15, 5};
    int cval [4] = '{1, 2, 5, 0};
    typedef struct { int kind; int data; } ev_t;
    ev_t sq [$];

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int k, input int d);
        ev_t e;
        e.kind = k;
        e.data = d;
        sq.push_back(e);
    endtask

    task automatic model_coin(input int ct, output bit ok);
        if (ct == 3 || credit + cval[ct] > MAXC) begin
            ok = 1'b0;
            push(EV_REJ, 0);
        end else begin
            ok = 1'b1;
            credit += cval[ct];
        end
    endtask

    task automatic model_sel(input int it, output bit ok);
        if (credit < price_tb[it]) begin
            ok = 1'b0;
            push(EV_DENY, 0);
        end else begin
            ok = 1'b1;
            left_after = credit - price_tb[it];
            push(EV_VEND, it);
            if (left_after > 0) push(EV_CHG, left_after);
            credit = 0;
        end
    endtask

    task automatic issue(input bit dc, input int ct, input bit ds, input int it, input bit tchk);
        bit cp = dc, sp = ds, ca, sa, cok = 1'b0, sok = 1'b0;
        int k = 0;
        int c0 = credit;
        @(negedge clk);
        coin_valid = dc;
        coin_type  = 2'(ct);
        sel_valid  = ds;
        sel_item   = 2'(it);
        while ((cp || sp) && k < 40) begin
            ca = 1'b0;
            sa = 1'b0;
            if (cp && coin_ready) begin model_coin(ct, cok); cp = 1'b0; ca = 1'b1; end
            if (sp && sel_ready) begin c0 = credit; model_sel(it, sok); sp = 1'b0; sa = 1'b1; end
            @(negedge clk);
            k++;
            if (ca) coin_valid = 1'b0;
            if (sa) sel_valid = 1'b0;
        end
        chk("handshake_done", int'(cp || sp), 0);
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        if (tchk && dc && !ds) begin
            if (cok) begin
                chk("add_op", int'(op), 2);
                chk("add_rw", int'(rw), 4);
                chk("add_ra", int'(ra), 4);
                chk("add_imm4", int'(imm4), cval[ct]);
                chk("coin_ready_busy", int'(coin_ready), 0);
                @(negedge clk);
                chk("coin_ready_again", int'(coin_ready), 1);
                chk("paid_after_add", int'(paid), credit);
            end else begin
                chk("coin_reject_pulse", int'(coin_reject), 1);
                chk("reject_no_write", int'(rw), 0);
            end
        end else if (tchk && ds && !dc) begin
            if (sok) begin
                chk("ldprice_op", int'(op), 3);
                chk("ldprice_rw", int'(rw), 5);
                chk("ldprice_imm4", int'(imm4), price_tb[it]);
                @(negedge clk);
                chk("deduct_op", int'(op), 1);
                chk("deduct_regs", int'({rw, ra, rb}), (4 << 8) | (4 << 4) | 5);
                @(negedge clk);
                chk("vend_pulse", int'(vend), 1);
                chk("vend_item", int'(vend_item), it);
                chk("paid_at_vend", int'(paid), left_after);
            end else begin
                chk("deny_pulse", int'(deny), 1);
                chk("deny_no_write", int'(rw), 0);
                chk("deny_paid_kept", int'(paid), c0);
            end
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (!(coin_ready && sel_ready && !change_valid && sq.size() == 0) && k < 80) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", int'(coin_ready && sel_ready && sq.size() == 0), 1);
        chk("paid_idle", int'(paid), credit);
    endtask

    task automatic do_cancel();
        int c0 = credit;
        @(negedge clk);
        cancel = 1'b1;
        if (c0 > 0) begin
            push(EV_CHG, c0);
            credit = 0;
        end
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_change_valid", int'(change_valid), int'(c0 > 0));
        if (c0 > 0) chk("cancel_change_units", int'(change_units), c0);
    endtask

    task automatic ev_check(input string name, input int kind, input int data);
        ev_t e;
        if (sq.size() == 0) begin
            chk({name, "_unexpected"}, kind * 1024 + data, 0);
        end else begin
            e = sq.pop_front();
            chk(name, kind * 1024 + data, e.kind * 1024 + e.data);
        end
    endtask

    // Consumer acknowledges change after a random delay, possibly in the rising cycle.
    initial begin : ack_gen
        forever begin
            @(negedge clk);
            change_ack = change_valid && ($urandom_range(0, 2) == 0);
        end
    end

    initial begin : monitor
        logic       cvp;
        logic [9:0] cu_hold;
        cvp = 1'b0;
        cu_hold = '0;
        forever begin
            @(negedge clk);
            if (coin_reject) ev_check("ev_reject", EV_REJ, 0);
            if (deny)        ev_check("ev_deny", EV_DENY, 0);
            if (vend)        ev_check("ev_vend", EV_VEND, int'(vend_item));
            if (change_valid && !cvp) begin
                ev_check("ev_change", EV_CHG, int'(change_units));
                cu_hold = change_units;
            end else if (change_valid && cvp) begin
                chk("change_units_stable", int'(change_units), int'(cu_hold));
            end
            cvp = change_valid;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion, expected summary before timeout");
        $fatal(1);
    end

    initial begin : main
        int r;
        repeat (3) @(negedge clk);
        chk("rst_coin_ready", int'(coin_ready), 0);
        chk("rst_sel_ready", int'(sel_ready), 0);
        chk("rst_pulses", int'({coin_reject, deny, vend, change_valid}), 0);
        chk("rst_op", int'(op), 3);
        chk("rst_rw", int'(rw), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("clr_rw", int'(rw), 4);
        chk("clr_imm4", int'(imm4), 0);
        chk("clr_not_ready", int'(coin_ready), 0);
        @(negedge clk);
        chk("idle_after_reset", int'(coin_ready), 1);
        chk("paid_cleared", int'(paid), 0);

        // quarter then dime
        issue(1, 2, 0, 0, 1); wait_idle();
        issue(1, 1, 0, 0, 1); wait_idle();
        chk("paid_seven", int'(paid), 7);
        // top up to 15 and buy item 1 (change 5)
        issue(1, 2, 0, 0, 1); wait_idle();
        issue(1, 1, 0, 0, 1); wait_idle();
        issue(1, 0, 0, 0, 1); wait_idle();
        issue(0, 0, 1, 1, 1); wait_idle();
        // paid 3, item 0 denied, then cancel returns 3
        issue(1, 1, 0, 0, 1); wait_idle();
        issue(1, 0, 0, 0, 1); wait_idle();
        issue(0, 0, 1, 0, 1); wait_idle();
        do_cancel(); wait_idle();
        do_cancel(); wait_idle();
        // credit ceiling
        for (int i = 0; i < 39; i++) begin issue(1, 2, 0, 0, 0); wait_idle(); end
        issue(1, 1, 0, 0, 0); wait_idle();
        issue(1, 0, 0, 0, 0); wait_idle();
        issue(1, 2, 0, 0, 1); wait_idle();
        issue(1, 3, 0, 0, 1); wait_idle();
        issue(1, 1, 0, 0, 1); wait_idle();
        issue(1, 0, 0, 0, 1); wait_idle();
        issue(0, 0, 1, 2, 1); wait_idle();
        // coin and selection together: coin must land first for item 3 to vend
        issue(1, 2, 1, 3, 0); wait_idle();

        // reset while DEDUCT is on the bus abandons the sale
        for (int i = 0; i < 3; i++) begin issue(1, 2, 0, 0, 0); wait_idle(); end
        @(negedge clk);
        sel_valid = 1'b1;
        sel_item  = 2'd1;
        chk("abort_sel_ready", int'(sel_ready), 1);
        @(negedge clk);
        sel_valid = 1'b0;
        chk("abort_ldprice_rw", int'(rw), 5);
        @(negedge clk);
        chk("abort_in_deduct", int'(op), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_no_vend", int'(vend), 0);
        @(negedge clk);
        chk("abort_clr_rw", int'(rw), 4);
        chk("abort_not_idle", int'(coin_ready), 0);
        @(negedge clk);
        chk("abort_idle", int'(coin_ready), 1);
        chk("abort_paid_zero", int'(paid), 0);
        credit = 0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5)       issue(1, $urandom_range(0, 3), 0, 0, 1);
            else if (r < 7)  issue(0, 0, 1, $urandom_range(0, 3), 1);
            else if (r < 8)  do_cancel();
            else             issue(1, $urandom_range(0, 3), 1, $urandom_range(0, 3), 0);
            wait_idle();
        end
        do_cancel(); wait_idle();

        repeat (3) @(negedge clk);
        chk("events_drained", sq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
